qbus_responder: RTL and testbench



---
 rtl/qbus_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_qbus_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbus_responder.sv
// Q-bus style slave behind the VM1 bus interface: steers each bus cycle to a
// synchronous memory port or a handshaked I/O port and closes the RPLY handshake.
module qbus_responder #(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned TIMEOUT     = 63,
   parameter logic [15:0] IO_BASE     = 16'o177600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        sync_i,
   input  logic        din_i,
   input  logic        dout_i,
   input  logic        wtbt_i,
   input  logic [15:0] addr_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o,
   output logic        rply_o,
   output logic        berr_o,
   output logic [14:0] mem_addr_o,
   output logic        mem_cs_o,
   output logic        mem_we_o,
   output logic [1:0]  mem_be_o,
   output logic [15:0] mem_wdata_o,
   input  logic [15:0] mem_rdata_i,
   output logic        io_req_o,
   output logic        io_we_o,
   output logic [15:0] io_addr_o,
   input  logic        io_ack_i,
   input  logic [15:0] io_rdata_i
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MEM   = 3'd1,
      ST_IO    = 3'd2,
      ST_REPLY = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        sync_q, sync_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic [1:0]  be_q, be_d;
   logic [15:0] rdata_q, rdata_d;
   logic        rply_q, rply_d;
   logic        berr_q, berr_d;
   logic        mem_cs_q, mem_cs_d;
   logic        mem_we_q, mem_we_d;
   logic        io_req_q, io_req_d;

   // A byte access selects the lane by address bit 0; a word access enables both.
   function automatic logic [1:0] byte_enables(input logic wtbt, input logic a0);
      logic [1:0] be;
      if (!wtbt) begin
         be = 2'b11;
      end else if (a0) begin
         be = 2'b10;
      end else begin
         be = 2'b01;
      end
      return be;
   endfunction

   // Next-state and output computation; nothing moves while ce is low.
   always_comb begin
      state_d  = state_q;
      sync_d   = sync_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      be_d     = be_q;
      rdata_d  = rdata_q;
      rply_d   = rply_q;
      berr_d   = berr_q;
      mem_cs_d = mem_cs_q;
      mem_we_d = mem_we_q;
      io_req_d = io_req_q;
      if (ce) begin
         sync_d   = sync_i;
         mem_we_d = 1'b0;
         berr_d   = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sync_i && !sync_q) begin
                  addr_d  = addr_i;
                  wdata_d = wdata_i;
                  write_d = dout_i;
                  be_d    = byte_enables(wtbt_i, addr_i[0]);
                  if (addr_i < IO_BASE) begin
                     state_d  = ST_MEM;
                     mem_cs_d = 1'b1;
                     mem_we_d = dout_i;
                     cnt_d    = 8'(WAIT_STATES);
                  end else begin
                     state_d  = ST_IO;
                     io_req_d = 1'b1;
                     cnt_d    = 8'(TIMEOUT);
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MEM: begin
               // An abort outranks the wait counter expiring on the same edge.
               if (!sync_i) begin
                  state_d  = ST_IDLE;
                  mem_cs_d = 1'b0;
               end else if (cnt_q == 8'd0) begin
                  if (!write_q) begin
                     rdata_d = mem_rdata_i;
                  end else begin
                     rdata_d = rdata_q;
                  end
                  mem_cs_d = 1'b0;
                  rply_d   = 1'b1;
                  state_d  = ST_REPLY;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_IO: begin
               // An ack outranks the timeout expiring on the same edge.
               if (!sync_i) begin
                  state_d  = ST_IDLE;
                  io_req_d = 1'b0;
               end else if (io_ack_i) begin
                  if (!write_q) begin
                     rdata_d = io_rdata_i;
                  end else begin
                     rdata_d = rdata_q;
                  end
                  io_req_d = 1'b0;
                  rply_d   = 1'b1;
                  state_d  = ST_REPLY;
               end else if (cnt_q == 8'd0) begin
                  io_req_d = 1'b0;
                  berr_d   = 1'b1;
                  state_d  = ST_HOLD;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_REPLY: begin
               if (!sync_i) begin
                  rply_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  rply_d = 1'b1;
               end
            end
            ST_HOLD: begin
               if (!sync_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               rply_d   = 1'b0;
               mem_cs_d = 1'b0;
               io_req_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         sync_q   <= 1'b0;
         cnt_q    <= 8'd0;
         addr_q   <= 16'd0;
         wdata_q  <= 16'd0;
         write_q  <= 1'b0;
         be_q     <= 2'b00;
         rdata_q  <= 16'd0;
         rply_q   <= 1'b0;
         berr_q   <= 1'b0;
         mem_cs_q <= 1'b0;
         mem_we_q <= 1'b0;
         io_req_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         be_q     <= be_d;
         rdata_q  <= rdata_d;
         rply_q   <= rply_d;
         berr_q   <= berr_d;
         mem_cs_q <= mem_cs_d;
         mem_we_q <= mem_we_d;
         io_req_q <= io_req_d;
      end
   end

   assign rdata_o     = rdata_q;
   assign rply_o      = rply_q;
   assign berr_o      = berr_q;
   assign mem_addr_o  = addr_q[15:1];
   assign mem_cs_o    = mem_cs_q;
   assign mem_we_o    = mem_we_q;
   assign mem_be_o    = be_q;
   assign mem_wdata_o = wdata_q;
   assign io_req_o    = io_req_q;
   assign io_we_o     = write_q;
   assign io_addr_o   = addr_q;

endmodule

// File: tb/tb_qbus_responder.sv
// Directed bench for qbus_responder: table of memory cycles plus hand-written
// I/O, timeout, abort, reset and clock-enable sequences.
module tb_qbus_responder;

   logic        clk, reset, ce;
   logic        sync_i, din_i, dout_i, wtbt_i;
   logic [15:0] addr_i, wdata_i, rdata_o;
   logic        rply_o, berr_o;
   logic [14:0] mem_addr_o;
   logic        mem_cs_o, mem_we_o;
   logic [1:0]  mem_be_o;
   logic [15:0] mem_wdata_o, mem_rdata_i;
   logic        io_req_o, io_we_o;
   logic [15:0] io_addr_o;
   logic        io_ack_i;
   logic [15:0] io_rdata_i;

   int n_tests = 0;
   int n_fail  = 0;

   qbus_responder #(.WAIT_STATES(1), .TIMEOUT(63), .IO_BASE(16'o177600)) dut (
      .clk(clk), .reset(reset), .ce(ce),
      .sync_i(sync_i), .din_i(din_i), .dout_i(dout_i), .wtbt_i(wtbt_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
      .rply_o(rply_o), .berr_o(berr_o),
      .mem_addr_o(mem_addr_o), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .io_req_o(io_req_o), .io_we_o(io_we_o), .io_addr_o(io_addr_o),
      .io_ack_i(io_ack_i), .io_rdata_i(io_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        wr;
      logic        rd;
      logic        bt;
      logic [15:0] mrd;
      logic [1:0]  exp_be;
      logic [14:0] exp_maddr;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic early_bad;

      vecs[0] = '{16'o001000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234, 2'b11, 15'o00400, 16'h1234};
      vecs[1] = '{16'o001001, 16'hAB00, 1'b1, 1'b0, 1'b1, 16'h9999, 2'b10, 15'o00400, 16'h1234};
      vecs[2] = '{16'o002000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h5A5A, 2'b01, 15'o01000, 16'h5A5A};
      vecs[3] = '{16'o000000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0F0F, 2'b11, 15'h0000,  16'h5A5A};
      vecs[4] = '{16'o177576, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hC0DE, 2'b11, 15'h7FBF,  16'hC0DE};
      vecs[5] = '{16'o177577, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0101, 2'b10, 15'h7FBF,  16'h0101};

      reset = 1'b1; ce = 1'b1;
      sync_i = 1'b0; din_i = 1'b0; dout_i = 1'b0; wtbt_i = 1'b0;
      addr_i = 16'd0; wdata_i = 16'd0; mem_rdata_i = 16'd0;
      io_ack_i = 1'b0; io_rdata_i = 16'd0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_rdata", rdata_o, 16'd0);
      chk("rst_rply", rply_o, 1'b0);
      chk("rst_berr", berr_o, 1'b0);
      chk("rst_mem", {mem_cs_o, mem_we_o, mem_be_o, mem_addr_o}, 19'd0);
      chk("rst_wdata", mem_wdata_o, 16'd0);
      chk("rst_io", {io_req_o, io_we_o, io_addr_o}, 18'd0);

      // Memory cycles from the table
      for (int i = 0; i < 6; i++) begin
         addr_i = vecs[i].addr; wdata_i = vecs[i].wdata;
         dout_i = vecs[i].wr; din_i = vecs[i].rd; wtbt_i = vecs[i].bt;
         mem_rdata_i = vecs[i].mrd;
         sync_i = 1'b1;
         tick();
         chk($sformatf("v%0d_cs_e0", i), mem_cs_o, 1'b1);
         chk($sformatf("v%0d_maddr", i), mem_addr_o, vecs[i].exp_maddr);
         chk($sformatf("v%0d_be", i), mem_be_o, vecs[i].exp_be);
         chk($sformatf("v%0d_we_e0", i), mem_we_o, vecs[i].wr);
         chk($sformatf("v%0d_ioreq", i), io_req_o, 1'b0);
         chk($sformatf("v%0d_rply_e0", i), rply_o, 1'b0);
         if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), mem_wdata_o, vecs[i].wdata);
         tick();
         chk($sformatf("v%0d_we_e1", i), mem_we_o, 1'b0);
         chk($sformatf("v%0d_rply_e1", i), rply_o, 1'b0);
         chk($sformatf("v%0d_cs_e1", i), mem_cs_o, 1'b1);
         tick();
         chk($sformatf("v%0d_rply_e2", i), rply_o, 1'b1);
         chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
         chk($sformatf("v%0d_cs_e2", i), mem_cs_o, 1'b0);
         sync_i = 1'b0; din_i = 1'b0; dout_i = 1'b0;
         tick();
         chk($sformatf("v%0d_rply_rel", i), rply_o, 1'b0);
         tick();
      end

      // I/O read, ack sampled at edge 3
      addr_i = 16'o177716; din_i = 1'b1; wtbt_i = 1'b0; sync_i = 1'b1;
      tick();
      chk("ior_req", io_req_o, 1'b1);
      chk("ior_addr", io_addr_o, 16'o177716);
      chk("ior_we", io_we_o, 1'b0);
      chk("ior_cs", mem_cs_o, 1'b0);
      tick(); tick();
      chk("ior_rply_e2", rply_o, 1'b0);
      io_ack_i = 1'b1; io_rdata_i = 16'o100200;
      tick();
      chk("ior_rply_e3", rply_o, 1'b1);
      chk("ior_rdata", rdata_o, 16'o100200);
      chk("ior_req_off", io_req_o, 1'b0);
      io_ack_i = 1'b0;
      tick();
      chk("ior_rply_hold", rply_o, 1'b1);
      sync_i = 1'b0; din_i = 1'b0;
      tick();
      chk("ior_rply_rel", rply_o, 1'b0);
      tick();

      // I/O write at IO_BASE with ack already high: reply after edge 1
      addr_i = 16'o177600; dout_i = 1'b1; wdata_i = 16'h1357; io_ack_i = 1'b1; sync_i = 1'b1;
      tick();
      chk("iow_req", io_req_o, 1'b1);
      chk("iow_we", io_we_o, 1'b1);
      chk("iow_addr", io_addr_o, 16'o177600);
      chk("iow_rply_e0", rply_o, 1'b0);
      tick();
      chk("iow_rply_e1", rply_o, 1'b1);
      chk("iow_rdata_kept", rdata_o, 16'o100200);
      io_ack_i = 1'b0; sync_i = 1'b0; dout_i = 1'b0;
      tick();
      chk("iow_rply_rel", rply_o, 1'b0);
      tick();

      // I/O write timeout
      addr_i = 16'o177714; dout_i = 1'b1; wdata_i = 16'h00FF; sync_i = 1'b1;
      tick();
      chk("to_req", io_req_o, 1'b1);
      early_bad = 1'b0;
      for (int e = 1; e <= 63; e++) begin
         tick();
         early_bad = early_bad | berr_o | rply_o | ~io_req_o;
      end
      chk("to_quiet", early_bad, 1'b0);
      tick();
      chk("to_berr", berr_o, 1'b1);
      chk("to_req_off", io_req_o, 1'b0);
      chk("to_rply", rply_o, 1'b0);
      tick();
      chk("to_berr_pulse", berr_o, 1'b0);
      tick(); tick();
      chk("to_hold", {rply_o, berr_o, io_req_o, mem_cs_o}, 4'd0);
      sync_i = 1'b0; dout_i = 1'b0;
      tick();
      chk("to_rel", {rply_o, berr_o}, 2'd0);
      tick();

      // Ack on the same edge the timeout expires: ack wins
      addr_i = 16'o177720; din_i = 1'b1; sync_i = 1'b1;
      tick();
      for (int e = 1; e <= 63; e++) tick();
      io_ack_i = 1'b1; io_rdata_i = 16'h4321;
      tick();
      chk("tie_rply", rply_o, 1'b1);
      chk("tie_berr", berr_o, 1'b0);
      chk("tie_rdata", rdata_o, 16'h4321);
      io_ack_i = 1'b0; sync_i = 1'b0; din_i = 1'b0;
      tick();
      chk("tie_rel", {rply_o, berr_o}, 2'd0);
      tick();

      // Abort in MEM while waiting
      addr_i = 16'o000100; din_i = 1'b1; mem_rdata_i = 16'hDEAD; sync_i = 1'b1;
      tick();
      chk("abm_cs_e0", mem_cs_o, 1'b1);
      sync_i = 1'b0;
      tick();
      chk("abm_cs_off", mem_cs_o, 1'b0);
      chk("abm_rply", rply_o, 1'b0);
      tick();
      chk("abm_rply2", {rply_o, berr_o}, 2'd0);
      chk("abm_rdata", rdata_o, 16'h4321);
      tick();

      // Abort on the edge where the wait counter reaches zero
      addr_i = 16'o000200; mem_rdata_i = 16'hBEEF; sync_i = 1'b1;
      tick(); tick();
      sync_i = 1'b0;
      tick();
      chk("abz_rply", rply_o, 1'b0);
      chk("abz_cs", mem_cs_o, 1'b0);
      chk("abz_rdata", rdata_o, 16'h4321);
      tick();

      // Abort in IO
      addr_i = 16'o177750; sync_i = 1'b1;
      tick(); tick();
      sync_i = 1'b0;
      tick();
      chk("abi_out", {io_req_o, berr_o, rply_o}, 3'd0);
      tick();
      chk("abi_berr", berr_o, 1'b0);
      din_i = 1'b0;
      tick();

      // Reset during REPLY, then re-service of the still-active cycle
      addr_i = 16'o000400; din_i = 1'b1; mem_rdata_i = 16'h7777; sync_i = 1'b1;
      tick(); tick(); tick();
      chk("rr_rply", rply_o, 1'b1);
      chk("rr_rdata", rdata_o, 16'h7777);
      reset = 1'b1;
      #1;
      chk("rr_async_rply", rply_o, 1'b0);
      chk("rr_async_rdata", rdata_o, 16'd0);
      chk("rr_async_mem", {mem_be_o, mem_addr_o, mem_cs_o}, 18'd0);
      chk("rr_async_io", io_addr_o, 16'd0);
      mem_rdata_i = 16'h8888;
      tick();
      reset = 1'b0;
      tick();
      chk("rr_re_cs", mem_cs_o, 1'b1);
      chk("rr_re_addr", mem_addr_o, 15'o00200);
      tick();
      chk("rr_re_rply_e1", rply_o, 1'b0);
      tick();
      chk("rr_re_rply", rply_o, 1'b1);
      chk("rr_re_rdata", rdata_o, 16'h8888);
      sync_i = 1'b0; din_i = 1'b0;
      tick();
      chk("rr_re_rel", rply_o, 1'b0);
      tick();

      // Clock enable low: a rising sync is not seen until ce returns
      ce = 1'b0;
      addr_i = 16'o000600; din_i = 1'b1; mem_rdata_i = 16'h2468; sync_i = 1'b1;
      tick(); tick();
      chk("ce_idle", mem_cs_o, 1'b0);
      ce = 1'b1;
      tick();
      chk("ce_cs", mem_cs_o, 1'b1);
      tick(); tick();
      chk("ce_rply", rply_o, 1'b1);
      chk("ce_rdata", rdata_o, 16'h2468);
      sync_i = 1'b0; din_i = 1'b0;
      tick();
      chk("ce_rel", rply_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
